// File: rtl/alu_reg_file.sv
// alu_reg_file: 32 x 64-bit operand register file with a carry flag; the last index is hardwired zero.
// Define REGFILE_BYPASS_EN to forward wr_data to a read port that addresses the register being written.
module alu_reg_file #(
  parameter int DATA_W   = 64,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              carry_we,
  input  logic              carry_d,
  output logic              carry_q
);

  // Indices at or above this value are either the zero register or out of range.
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(NUM_REGS - 1);

  logic [DATA_W-1:0] rf_word [NUM_REGS];
  logic              wr_ok;
  logic              fwd_en;
  logic              carry_next_d;

  assign wr_ok = wr_en && (wr_addr < ZERO_IDX);

`ifdef REGFILE_BYPASS_EN
  // Forwarding is suppressed during reset so every read port shows zero while rst_n is low.
  assign fwd_en = rst_n && wr_en;
`else
  assign fwd_en = 1'b0;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      if (gi == NUM_REGS - 1) begin : g_zero
        assign rf_word[gi] = '0;
      end else begin : g_store
        logic [DATA_W-1:0] word_q;
        logic [DATA_W-1:0] word_d;
        logic              hit;

        assign hit = wr_ok && (wr_addr == ADDR_W'(gi));

        always_comb begin
          word_d = word_q;
          if (hit) begin
            word_d = wr_data;
          end
        end

        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            word_q <= '0;
          end else begin
            word_q <= word_d;
          end
        end

        assign rf_word[gi] = word_q;
      end
    end

    for (gi = 0; gi < 2; gi++) begin : g_rd
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] word;

      if (gi == 0) begin : g_sel_a
        assign addr = rd_addr_a;
      end else begin : g_sel_b
        assign addr = rd_addr_b;
      end

      always_comb begin
        word = '0;
        if (addr < ZERO_IDX) begin
          word = rf_word[addr];
          if (fwd_en && (wr_addr == addr)) begin
            word = wr_data;
          end
        end
      end
    end
  endgenerate

  assign rd_data_a = g_rd[0].word;
  assign rd_data_b = g_rd[1].word;

  always_comb begin
    carry_next_d = carry_q;
    if (carry_we) begin
      carry_next_d = carry_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_q <= 1'b0;
    end else begin
      carry_q <= carry_next_d;
    end
  end

endmodule

// File: tb/tb_alu_reg_file.sv
// Randomized bench for alu_reg_file: array model of the register file, per-cycle comparison,
// and directed cases with literal expectations.
module tb_alu_reg_file;
  localparam int DW = 64;
  localparam int NR = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] rd_addr_a, rd_addr_b, wr_addr;
  logic [DW-1:0] rd_data_a, rd_data_b, wr_data;
  logic          wr_en, carry_we, carry_d, carry_q;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  logic [DW-1:0] model_rf [NR];
  logic          model_carry;

  alu_reg_file #(.DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .carry_we(carry_we), .carry_d(carry_d), .carry_q(carry_q)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference: a plain array of registers plus a carry bit.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NR; i++) model_rf[i] <= '0;
      model_carry <= 1'b0;
    end else begin
      if (wr_en && (int'(wr_addr) != NR - 1)) model_rf[wr_addr] <= wr_data;
      if (carry_we) model_carry <= carry_d;
    end
  end

  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
    if (int'(a) == NR - 1) return '0;
`ifdef REGFILE_BYPASS_EN
    if (rst_n && wr_en && (wr_addr == a)) return wr_data;
`endif
    return model_rf[a];
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_rd_a", rd_data_a, exp_rd(rd_addr_a));
      check("cyc_rd_b", rd_data_b, exp_rd(rd_addr_b));
      check("cyc_carry", {63'd0, carry_q}, {63'd0, model_carry});
    end
  end

  task automatic drive(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic [AW-1:0] ra, input logic [AW-1:0] rb,
                       input logic cwe, input logic cd);
    wr_en = we; wr_addr = wa; wr_data = wd;
    rd_addr_a = ra; rd_addr_b = rb;
    carry_we = cwe; carry_d = cd;
    $display("TXN t=%0t we=%0b wa=%0d wd=%h ra=%0d rb=%0d cwe=%0b cd=%0b",
             $time, we, wa, wd, ra, rb, cwe, cd);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  logic [DW-1:0] exp_t4;

  initial begin
    rst_n = 1'b1;
    drive(1'b0, '0, '0, '0, '0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("reset_rd_a", rd_data_a, 64'd0);
    check("reset_carry", {63'd0, carry_q}, 64'd0);
    repeat (2) @(posedge clk);

    // First write lands on the first posedge after rst_n rises.
    @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;
    drive(1'b1, 5'd9, 64'h0BAD_F00D_0000_0009, 5'd9, 5'd9, 1'b0, 1'b0);
    next_cycle();
    drive(1'b0, 5'd0, '0, 5'd9, 5'd0, 1'b0, 1'b0);
    @(negedge clk);
    check("first_write", rd_data_a, 64'h0BAD_F00D_0000_0009);

    // Write then read back.
    next_cycle();
    drive(1'b1, 5'd5, 64'hDEAD_BEEF_0123_4567, 5'd5, 5'd0, 1'b0, 1'b0);
    next_cycle();
    drive(1'b0, 5'd0, '0, 5'd5, 5'd5, 1'b0, 1'b0);
    @(negedge clk);
    check("wr_rd_a", rd_data_a, 64'hDEAD_BEEF_0123_4567);
    check("wr_rd_b", rd_data_b, 64'hDEAD_BEEF_0123_4567);

    // Writes to the zero register are dropped.
    next_cycle();
    drive(1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 5'd31, 5'd31, 1'b0, 1'b0);
    @(negedge clk);
    check("x31_same_cycle", rd_data_b, 64'd0);
    next_cycle();
    drive(1'b0, 5'd0, '0, 5'd31, 5'd31, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("x31_a", rd_data_a, 64'd0);
      check("x31_b", rd_data_b, 64'd0);
      next_cycle();
    end

    // Same-cycle write/read of register 7.
    drive(1'b1, 5'd7, 64'h1, 5'd0, 5'd7, 1'b0, 1'b0);
    next_cycle();
    drive(1'b1, 5'd7, 64'h2, 5'd0, 5'd7, 1'b0, 1'b0);
`ifdef REGFILE_BYPASS_EN
    exp_t4 = 64'h2;
`else
    exp_t4 = 64'h1;
`endif
    @(negedge clk);
    check("same_cycle_before", rd_data_b, exp_t4);
    next_cycle();
    drive(1'b0, 5'd0, '0, 5'd0, 5'd7, 1'b0, 1'b0);
    @(negedge clk);
    check("same_cycle_after", rd_data_b, 64'h2);

    // Carry set then held for three cycles with carry_we low.
    next_cycle();
    drive(1'b0, 5'd0, '0, 5'd0, 5'd0, 1'b1, 1'b1);
    next_cycle();
    drive(1'b0, 5'd0, '0, 5'd0, 5'd0, 1'b0, 1'b0);
    @(negedge clk);
    check("carry_set", {63'd0, carry_q}, 64'd1);
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      @(negedge clk);
      check("carry_hold", {63'd0, carry_q}, 64'd1);
    end

    // Asynchronous reset between edges clears everything at once.
    drive(1'b0, 5'd0, '0, 5'd5, 5'd7, 1'b0, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_a", rd_data_a, 64'd0);
    check("async_rst_b", rd_data_b, 64'd0);
    check("async_rst_carry", {63'd0, carry_q}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Write pending while reset is asserted at the edge is discarded.
    next_cycle();
    drive(1'b1, 5'd3, 64'h3333, 5'd3, 5'd3, 1'b0, 1'b0);
    next_cycle();
    drive(1'b1, 5'd3, 64'h0ABC_0ABC_0ABC_0ABC, 5'd3, 5'd3, 1'b1, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    drive(1'b0, 5'd0, '0, 5'd3, 5'd3, 1'b0, 1'b0);
    @(negedge clk);
    check("rst_mid_write", rd_data_a, 64'd0);
    check("rst_mid_carry", {63'd0, carry_q}, 64'd0);

    // Random traffic, biased so reads often hit the write target.
    for (int n = 0; n < 400; n++) begin
      logic [AW-1:0] wa, ra, rb;
      next_cycle();
      wa = AW'($urandom_range(0, NR - 1));
      ra = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, NR - 1));
      rb = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, NR - 1));
      drive(1'($urandom_range(0, 1)), wa, {$urandom, $urandom}, ra, rb,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 63) == 0) begin
        #1 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
    end

    next_cycle();
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
